// File: rtl/cu_irq_fsm.sv
// Control-unit sequencer: fetch/decode/execute/memory/writeback with prioritized interrupt entry.
// Define CU_BUS_TIMEOUT_EN to enable the fetch/memory acknowledge watchdog (bus_err_o, vector NUM_IRQ).
module cu_irq_fsm #(
    parameter int NUM_IRQ     = 4,
    parameter int TIMEOUT_CYC = 16,
    localparam int VW         = $clog2(NUM_IRQ + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inst_ack_i,
    input  logic [6:0]         op_i,
    input  logic [2:0]         func_i,
    input  logic               data_ack_i,
    input  logic               port_ack_i,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic [NUM_IRQ-1:0] irq_mask_i,
    output logic [2:0]         state_o,
    output logic               inst_stb_o,
    output logic               alu_en_o,
    output logic               data_stb_o,
    output logic               data_we_o,
    output logic               port_stb_o,
    output logic               port_we_o,
    output logic               reg_wr_o,
    output logic               pc_en_o,
    output logic               sleep_o,
    output logic               int_o,
    output logic [VW-1:0]      int_vec_o,
    output logic               bus_err_o
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_INT       = 3'd3,
        S_MEM       = 3'd4,
        S_WRITEBACK = 3'd5
    } state_e;

    state_e        state_q, state_d;
    state_e        mem_done_state;
    logic [VW-1:0] int_vec_q, int_vec_d;
    logic [VW-1:0] win_idx;
    logic [NUM_IRQ-1:0] pend;
    logic          inter;
    logic          timeout;

    logic is_alu_imm, is_mem, is_shift, is_alu_reg, is_misc;
    logic is_ldm, is_stm, is_inp, is_out, is_wait, is_stby;
    logic ack_match;

    assign is_alu_imm = ~op_i[6];
    assign is_mem     = (op_i[6:5] == 2'b10);
    assign is_shift   = (op_i[6:4] == 3'b110);
    assign is_alu_reg = (op_i[6:3] == 4'b1110);
    assign is_misc    = (op_i == 7'b1111110);

    assign is_ldm  = is_mem & (func_i[2:1] == 2'b00);
    assign is_stm  = is_mem & (func_i[2:1] == 2'b01);
    assign is_inp  = is_mem & (func_i[2:1] == 2'b10);
    assign is_out  = is_mem & (func_i[2:1] == 2'b11);
    assign is_wait = is_misc & (func_i == 3'b100);
    assign is_stby = is_misc & (func_i == 3'b101);

    assign ack_match = ((is_ldm | is_stm) & data_ack_i) | ((is_inp | is_out) & port_ack_i);

    assign pend  = irq_i & irq_mask_i;
    assign inter = |pend;

    // Scanning downward leaves the lowest pending line as the winner.
    always_comb begin
        win_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pend[i]) begin
                win_idx = VW'(i);
            end
        end
    end

    // Loads finish through writeback; stores return to fetch or take a pending interrupt.
    always_comb begin
        if (is_ldm | is_inp) begin
            mem_done_state = S_WRITEBACK;
        end else begin
            mem_done_state = inter ? S_INT : S_FETCH;
        end
    end

`ifdef CU_BUS_TIMEOUT_EN
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       waiting;

    assign waiting = ((state_q == S_FETCH) & ~inst_ack_i) | ((state_q == S_MEM) & ~ack_match);
    assign timeout = waiting & (wait_cnt_q == 8'(TIMEOUT_CYC - 1));

    always_comb begin
        if (state_d != state_q) begin
            wait_cnt_d = '0;
        end else if (waiting) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end else begin
            wait_cnt_d = wait_cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            int_vec_q <= '0;
        end else begin
            state_q   <= state_d;
            int_vec_q <= int_vec_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: begin
                if (inst_ack_i)   state_d = S_DECODE;
                else if (timeout) state_d = S_INT;
                else              state_d = S_FETCH;
            end
            S_DECODE: begin
                if (is_wait | is_stby) begin
                    state_d = inter ? S_INT : S_DECODE;
                end else if (is_alu_imm | is_alu_reg | is_shift | is_mem) begin
                    state_d = S_EXECUTE;
                end else begin
                    state_d = inter ? S_INT : S_FETCH;
                end
            end
            S_EXECUTE: begin
                if (!is_mem)        state_d = S_WRITEBACK;
                else if (ack_match) state_d = mem_done_state;
                else                state_d = S_MEM;
            end
            S_MEM: begin
                if (ack_match)    state_d = mem_done_state;
                else if (timeout) state_d = S_INT;
                else              state_d = S_MEM;
            end
            S_WRITEBACK: state_d = inter ? S_INT : S_FETCH;
            S_INT:       state_d = S_FETCH;
            default:     state_d = S_FETCH;
        endcase
    end

    // A bus timeout outranks pending interrupts when choosing the vector.
    always_comb begin
        int_vec_d = int_vec_q;
        if (state_d == S_INT) begin
            int_vec_d = timeout ? VW'(NUM_IRQ) : win_idx;
        end
    end

    always_comb begin
        inst_stb_o = 1'b0;
        alu_en_o   = 1'b0;
        data_stb_o = 1'b0;
        data_we_o  = 1'b0;
        port_stb_o = 1'b0;
        port_we_o  = 1'b0;
        reg_wr_o   = 1'b0;
        sleep_o    = 1'b0;
        int_o      = 1'b0;
        pc_en_o    = 1'b0;
        bus_err_o  = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH:  inst_stb_o = 1'b1;
                S_DECODE: sleep_o = is_stby;
                S_EXECUTE, S_MEM: begin
                    alu_en_o   = (state_q == S_EXECUTE) & ~is_mem;
                    data_stb_o = is_ldm | is_stm;
                    data_we_o  = is_stm;
                    port_stb_o = is_inp | is_out;
                    port_we_o  = is_out;
                end
                S_WRITEBACK: reg_wr_o = 1'b1;
                S_INT:       int_o = 1'b1;
                default: ;
            endcase
            // Instruction retirement; watchdog exits do not advance the PC.
            pc_en_o = ((state_q == S_DECODE) | (state_q == S_EXECUTE) |
                       (state_q == S_MEM) | (state_q == S_WRITEBACK)) &
                      ((state_d == S_FETCH) | (state_d == S_INT)) & ~timeout;
            bus_err_o = timeout;
        end
    end

    assign state_o   = state_q;
    assign int_vec_o = rst ? '0 : int_vec_q;

endmodule
